row_flip_sequencer: RTL
=======================

ROW_FLIP_SEQUENCER -- requirements
Module: row_flip_sequencer

Interface
REQ-001 Parameter SIDE, default 4, number of rows per frame and elements per row; legal range 2..16.
REQ-002 Parameter ELEM_W, default 1, bits per element; row width RW = SIDE*ELEM_W.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  synchronous frame abort, active-high.
REQ-006 in_valid  input  1  in_row carries a valid row.
REQ-007 in_ready  output  1  block accepts a row this cycle.
REQ-008 in_row  input  RW  input row; element k at bits [k*ELEM_W +: ELEM_W].
REQ-009 out_valid  output  1  out_row carries a valid row.
REQ-010 out_ready  input  1  downstream accepts the row this cycle.
REQ-011 out_row  output  RW  output row, element layout unchanged from input.
REQ-012 out_last  output  1  high with out_valid on the final row of a frame.
REQ-013 busy  output  1  high whenever state is not FILL with zero rows held.
REQ-014 frames_done  output  8  count of completely drained frames, wraps 255->0.

Function
REQ-015 The block SHALL buffer one SIDE x RW frame and emit its rows in reversed order: output position j carries input row SIDE-1-j; elements within a row are not reordered.
REQ-016 States SHALL be FILL and DRAIN only; reset state is FILL.
REQ-017 An input handshake occurs when in_valid and in_ready are both high at a rising edge; an output handshake when out_valid and out_ready are both high.
REQ-018 In FILL, in_ready SHALL be 1 and out_valid 0; each input handshake writes in_row to buffer slot wr_idx and increments wr_idx (0..SIDE-1).
REQ-019 The input handshake with wr_idx = SIDE-1 SHALL move state to DRAIN with rd_idx = SIDE-1; out_valid SHALL be 1 the following cycle (latency: 1 cycle from last accepted row to first output row).
REQ-020 In DRAIN, in_ready SHALL be 0, out_valid 1, out_row = slot rd_idx, out_last = (rd_idx == 0).
REQ-021 Each output handshake in DRAIN SHALL decrement rd_idx; out_row SHALL hold stable while out_valid is high and out_ready low.
REQ-022 The output handshake with rd_idx = 0 SHALL return state to FILL with wr_idx = 0 and increment frames_done; in_ready SHALL be 1 the following cycle.
REQ-023 in_valid in DRAIN SHALL be ignored; out_ready in FILL SHALL be ignored.
REQ-024 flush high at a rising edge SHALL force FILL, wr_idx = 0, rd_idx = 0, discard the partial or undrained frame, and not change frames_done; flush overrides any handshake in the same cycle.
REQ-025 Buffer contents SHALL never be visible on out_row except during DRAIN; out_row SHALL be 0 in FILL.
REQ-026 Zero-rows-held means FILL with wr_idx = 0; busy SHALL be 0 only then.

Reset
REQ-027 rst_n low SHALL immediately, without a clock edge, force state FILL, wr_idx 0, rd_idx 0, frames_done 0, in_ready 1, out_valid 0, out_last 0, out_row 0, busy 0.
REQ-028 Buffer storage need not be reset; no output may depend on unwritten storage.
REQ-029 Reset asserted mid-FILL or mid-DRAIN SHALL discard the frame; first handshake after deassertion is treated as row 0.

Verification (SIDE=4, ELEM_W=1)
REQ-030 Rows 0x1,0x2,0x4,0x8 with out_ready=1 -> out_row 0x8,0x4,0x2,0x1 on 4 consecutive cycles starting 1 cycle after row 0x8 accepted; out_last only with 0x1; frames_done 1.
REQ-031 Same frame, out_ready toggling 1,0,0,1,1,0,1 -> same order, out_row stable during stalls, in_ready 0 until cycle after 0x1 handshake.
REQ-032 in_valid held high throughout DRAIN with in_row=0xF -> 0xF never captured; next frame starts only after drain.
REQ-033 rst_n pulsed low after 2 rows accepted -> outputs at reset values asynchronously; new frame 0x3,0x5,0x6,0x9 -> outputs 0x9,0x6,0x5,0x3.
REQ-034 flush asserted during DRAIN after first output -> state FILL, out_valid 0 next cycle, frames_done unchanged.
REQ-035 256 back-to-back frames -> frames_done wraps to 0; throughput 4 rows in, 4 rows out per 8 cycles minimum.

Source files
------------

// File: rtl/row_flip_sequencer.sv
// row_flip_sequencer
//   Buffers one SIDE x SIDE frame of rows and replays the rows in reverse
//   order (last row in is the first row out). Elements inside a row keep
//   their positions.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   flush        in   synchronous frame abort (active-high)
//   in_valid     in   in_row carries a row
//   in_ready     out  a row is accepted this cycle (FILL only)
//   in_row       in   RW-bit row, element k at [k*ELEM_W +: ELEM_W]
//   out_valid    out  out_row carries a row (DRAIN only)
//   out_ready    in   downstream takes the row this cycle
//   out_row      out  RW-bit row, zero outside DRAIN
//   out_last     out  final row of the frame
//   busy         out  low only when FILL holds no rows
//   frames_done  out  8-bit wrapping count of fully drained frames
module row_flip_sequencer #(
  parameter int SIDE   = 4,
  parameter int ELEM_W = 1,
  localparam int RW    = SIDE * ELEM_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [RW-1:0] in_row,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_row,
  output logic          out_last,
  output logic          busy,
  output logic [7:0]    frames_done
);

  localparam int IW = (SIDE > 1) ? $clog2(SIDE) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(SIDE - 1);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t        state, state_nx;
  logic [IW-1:0] wr_idx, wr_idx_nx;
  logic [IW-1:0] rd_idx, rd_idx_nx;
  logic [7:0]    frames_done_nx;
  logic          wr_en;

  // Frame storage is never reset: it is only observable in DRAIN, and DRAIN
  // is reachable only after all SIDE slots were written in the same frame.
  logic [RW-1:0] mem [SIDE];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= in_row;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FILL;
      wr_idx      <= '0;
      rd_idx      <= '0;
      frames_done <= 8'd0;
    end else begin
      state       <= state_nx;
      wr_idx      <= wr_idx_nx;
      rd_idx      <= rd_idx_nx;
      frames_done <= frames_done_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    wr_idx_nx      = wr_idx;
    rd_idx_nx      = rd_idx;
    frames_done_nx = frames_done;
    wr_en          = 1'b0;

    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_row   = '0;
    out_last  = 1'b0;
    busy      = 1'b1;

    // Outputs depend only on state, so the async reset reaches them at once.
    case (state)
      FILL: begin
        in_ready = 1'b1;
        busy     = (wr_idx != '0);
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_row   = mem[rd_idx];
        out_last  = (rd_idx == '0);
      end
      default: ;
    endcase

    // Flush wins over any handshake in the same cycle.
    if (flush) begin
      state_nx  = FILL;
      wr_idx_nx = '0;
      rd_idx_nx = '0;
    end else begin
      case (state)
        FILL: begin
          if (in_valid) begin
            wr_en = 1'b1;
            if (wr_idx == LAST_IDX) begin
              state_nx  = DRAIN;
              rd_idx_nx = LAST_IDX;
              wr_idx_nx = '0;
            end else begin
              wr_idx_nx = wr_idx + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (rd_idx == '0) begin
              state_nx       = FILL;
              wr_idx_nx      = '0;
              frames_done_nx = frames_done + 8'd1;
            end else begin
              rd_idx_nx = rd_idx - 1'b1;
            end
          end
        end
        default: state_nx = FILL;
      endcase
    end
  end

endmodule
